// File: rtl/l1_conv_sched.sv
// Layer-1 convolution scheduler: per output channel, load kernel weights, run one conv pass,
// then drain the local output RAM word by word to the downstream buffer.
module l1_conv_sched #(
    parameter int unsigned NUM_CH  = 6,
    parameter int unsigned OUT_PIX = 25,
    parameter int unsigned AW      = 5,
    parameter int unsigned CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Start_i,
    input  logic          Abort_i,
    output logic          Busy_o,
    output logic          Done_o,
    output logic          WgtLoadReq_o,
    input  logic          WgtLoadAck_i,
    output logic [CW-1:0] WgtCh_o,
    output logic          ConvValid_o,
    input  logic          ConvReady_i,
    output logic          OutRamRe_o,
    output logic [AW-1:0] OutRamRdAddr_o,
    output logic          DrainValid_o,
    input  logic          DrainReady_i,
    output logic          DrainLast_o,
    output logic [CW-1:0] DrainCh_o
);

    typedef enum logic [2:0] {StIdle, StLoad, StConv, StRd, StXfer, StDone} stateT;

    localparam logic [CW-1:0] LastCh   = CW'(NUM_CH - 1);
    localparam logic [AW-1:0] LastAddr = AW'(OUT_PIX - 1);

    stateT         stateQ, stateD;
    logic [CW-1:0] chQ, chD;
    logic [AW-1:0] rdAddrQ, rdAddrD;
    logic          lastWord;

    assign lastWord = (rdAddrQ == LastAddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= StIdle;
            chQ     <= '0;
            rdAddrQ <= '0;
        end else begin
            stateQ  <= stateD;
            chQ     <= chD;
            rdAddrQ <= rdAddrD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        chD     = chQ;
        rdAddrD = rdAddrQ;
        unique case (stateQ)
            StIdle: begin
                if (Start_i) begin
                    stateD  = StLoad;
                    chD     = '0;
                    rdAddrD = '0;
                end
            end
            StLoad: begin
                if (WgtLoadAck_i) stateD = StConv;
            end
            StConv: begin
                if (ConvReady_i) begin
                    stateD  = StRd;
                    rdAddrD = '0;
                end
            end
            StRd: stateD = StXfer;
            StXfer: begin
                // RAM read is stalled here, so its output data stays put until accepted
                if (DrainReady_i) begin
                    if (!lastWord) begin
                        rdAddrD = rdAddrQ + 1'b1;
                        stateD  = StRd;
                    end else if (chQ != LastCh) begin
                        chD     = chQ + 1'b1;
                        rdAddrD = '0;
                        stateD  = StLoad;
                    end else begin
                        rdAddrD = '0;
                        stateD  = StDone;
                    end
                end
            end
            StDone: begin
                stateD = StIdle;
                chD    = '0;
            end
            default: begin
                stateD  = StIdle;
                chD     = '0;
                rdAddrD = '0;
            end
        endcase
        if (Abort_i) begin
            stateD  = StIdle;
            chD     = '0;
            rdAddrD = '0;
        end
    end

    assign Busy_o         = (stateQ != StIdle);
    assign Done_o         = (stateQ == StDone);
    assign WgtLoadReq_o   = (stateQ == StLoad);
    assign WgtCh_o        = chQ;
    assign ConvValid_o    = (stateQ == StConv);
    assign OutRamRe_o     = (stateQ == StRd);
    assign OutRamRdAddr_o = rdAddrQ;
    assign DrainValid_o   = (stateQ == StXfer);
    assign DrainLast_o    = (stateQ == StXfer) && lastWord;
    assign DrainCh_o      = chQ;

endmodule

// File: tb/tb_l1_conv_sched.sv
// Directed bench for l1_conv_sched: a cycle-level responder plays weight loader, conv engine
// and downstream sink, logging what the scheduler did; each test task checks the logs.
module tb_l1_conv_sched;
    localparam int NUM_CH = 6, OUT_PIX = 25, AW = 5, CW = 3;

    logic clk, rst, Start_i, Abort_i, WgtLoadAck_i, ConvReady_i, DrainReady_i;
    logic Busy_o, Done_o, WgtLoadReq_o, ConvValid_o, OutRamRe_o, DrainValid_o, DrainLast_o;
    logic [CW-1:0] WgtCh_o, DrainCh_o;
    logic [AW-1:0] OutRamRdAddr_o;

    int checks = 0;
    int errors = 0;

    int ackDelay, convDelay, convHold;
    bit ackLevel, bpEn, abortEn, startConv1, startDone;

    int loadChQ[$], readQ[$], accQ[$];
    int convEntries, rdFromConv, convLowOk, readGapViol, holdViol, bpXferCycles, doneCnt;
    logic busyInDone, postBusy2;
    logic [31:0] postSnap;

    l1_conv_sched #(.NUM_CH(NUM_CH), .OUT_PIX(OUT_PIX), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .Start_i(Start_i), .Abort_i(Abort_i), .Busy_o(Busy_o),
        .Done_o(Done_o), .WgtLoadReq_o(WgtLoadReq_o), .WgtLoadAck_i(WgtLoadAck_i),
        .WgtCh_o(WgtCh_o), .ConvValid_o(ConvValid_o), .ConvReady_i(ConvReady_i),
        .OutRamRe_o(OutRamRe_o), .OutRamRdAddr_o(OutRamRdAddr_o), .DrainValid_o(DrainValid_o),
        .DrainReady_i(DrainReady_i), .DrainLast_o(DrainLast_o), .DrainCh_o(DrainCh_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] outs();
        return 32'({Busy_o, Done_o, WgtLoadReq_o, WgtCh_o, ConvValid_o, OutRamRe_o,
                    OutRamRdAddr_o, DrainValid_o, DrainLast_o, DrainCh_o});
    endfunction

    task automatic clear_knobs();
        ackDelay = 2; convDelay = 30; convHold = 1;
        ackLevel = 0; bpEn = 0; abortEn = 0; startConv1 = 0; startDone = 0;
    endtask

    // Drives one layer run from IDLE; result 1 = Done seen, 2 = abort issued, 0 = budget expired
    task automatic respond(input int maxCyc, output int result);
        int loadCyc, convCyc, readyLeft, xferCyc, lastReadCyc;
        bit prevConv, prevReq, checkLow;
        logic [CW-1:0] holdCh;
        logic [AW-1:0] holdAddr;
        loadChQ.delete(); readQ.delete(); accQ.delete();
        convEntries = 0; rdFromConv = 0; convLowOk = 0; readGapViol = 0; holdViol = 0;
        bpXferCycles = 0; doneCnt = 0; busyInDone = 0;
        loadCyc = 0; convCyc = 0; readyLeft = 0; xferCyc = 0; lastReadCyc = -10;
        prevConv = 0; prevReq = 0; checkLow = 0; holdCh = '0; holdAddr = '0;
        result = 0;
        for (int c = 0; c < maxCyc; c++) begin
            @(negedge clk);
            Start_i = (c == 0);
            Abort_i = 1'b0;
            DrainReady_i = 1'b0;
            if (WgtLoadReq_o) begin
                if (!prevReq) loadChQ.push_back(int'(WgtCh_o));
                loadCyc++;
            end else loadCyc = 0;
            if (ConvValid_o) begin
                if (!prevConv) convEntries++;
                convCyc++;
            end else convCyc = 0;
            if (checkLow) begin
                if (!ConvValid_o && OutRamRe_o) convLowOk++;
                checkLow = 0;
            end
            if (convCyc == convDelay) begin
                readyLeft = convHold;
                checkLow = 1;
            end
            ConvReady_i = (readyLeft > 0);
            if (readyLeft > 0) readyLeft--;
            if (ackLevel)
                WgtLoadAck_i = (loadCyc >= ackDelay) || (WgtLoadAck_i && convCyc > 0 && convCyc < 3);
            else
                WgtLoadAck_i = (loadCyc == ackDelay);
            if (startConv1 && ConvValid_o && WgtCh_o == 3'd1 && convCyc == 5) Start_i = 1'b1;
            if (OutRamRe_o) begin
                readQ.push_back(int'(WgtCh_o) * 32 + int'(OutRamRdAddr_o));
                if (prevConv) rdFromConv++;
                else if (c - lastReadCyc != 2) readGapViol++;
                lastReadCyc = c;
            end
            if (DrainValid_o) begin
                xferCyc++;
                if (xferCyc == 1) begin
                    holdCh = DrainCh_o;
                    holdAddr = OutRamRdAddr_o;
                end else if (DrainCh_o !== holdCh || OutRamRdAddr_o !== holdAddr || OutRamRe_o)
                    holdViol++;
                DrainReady_i = 1'b1;
                if (bpEn && DrainCh_o == 3'd2 && OutRamRdAddr_o == 5'd12) begin
                    bpXferCycles = xferCyc;
                    DrainReady_i = (xferCyc > 5);
                end
                if (abortEn && DrainCh_o == 3'd3 && OutRamRdAddr_o == 5'd7) begin
                    Abort_i = 1'b1;
                    result = 2;
                    break;
                end
                if (DrainReady_i)
                    accQ.push_back(int'(DrainCh_o) * 64 + int'(OutRamRdAddr_o) * 2
                                   + int'(DrainLast_o));
            end else xferCyc = 0;
            if (Done_o) begin
                doneCnt++;
                busyInDone = Busy_o;
                if (startDone) Start_i = 1'b1;
                result = 1;
                break;
            end
            prevConv = ConvValid_o;
            prevReq = WgtLoadReq_o;
        end
        @(negedge clk);
        postSnap = outs();
        if (Done_o) doneCnt++;
        Start_i = 0; Abort_i = 0; DrainReady_i = 0; ConvReady_i = 0; WgtLoadAck_i = 0;
        @(negedge clk);
        postBusy2 = Busy_o;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (outs() !== 32'd0) begin errors++; $display("FAIL reset_outs got %0h want 0", outs()); end
        @(negedge clk); rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (outs() !== 32'd0) begin errors++; $display("FAIL reset_idle got %0h want 0", outs()); end
        end
    endtask

    task automatic test_nominal();
        int r;
        clear_knobs();
        respond(3000, r);
        checks++; if (r != 1) begin errors++; $display("FAIL nom_result got %0d want 1", r); end
        checks++; if (loadChQ.size() != NUM_CH) begin errors++; $display("FAIL nom_loads got %0d want %0d", loadChQ.size(), NUM_CH); end
        for (int i = 0; i < loadChQ.size() && i < NUM_CH; i++) begin
            checks++; if (loadChQ[i] != i) begin errors++; $display("FAIL nom_wgtch[%0d] got %0d want %0d", i, loadChQ[i], i); end
        end
        checks++; if (convEntries != NUM_CH) begin errors++; $display("FAIL nom_convs got %0d want %0d", convEntries, NUM_CH); end
        checks++; if (rdFromConv != NUM_CH) begin errors++; $display("FAIL nom_conv2rd got %0d want %0d", rdFromConv, NUM_CH); end
        checks++; if (readQ.size() != NUM_CH * OUT_PIX) begin errors++; $display("FAIL nom_reads got %0d want 150", readQ.size()); end
        for (int i = 0; i < readQ.size() && i < NUM_CH * OUT_PIX; i++) begin
            checks++; if (readQ[i] != (i / OUT_PIX) * 32 + i % OUT_PIX) begin errors++; $display("FAIL nom_read[%0d] got %0d want %0d", i, readQ[i], (i / OUT_PIX) * 32 + i % OUT_PIX); end
        end
        checks++; if (accQ.size() != NUM_CH * OUT_PIX) begin errors++; $display("FAIL nom_accepts got %0d want 150", accQ.size()); end
        for (int i = 0; i < accQ.size() && i < NUM_CH * OUT_PIX; i++) begin
            checks++; if (accQ[i] != (i / OUT_PIX) * 64 + (i % OUT_PIX) * 2 + int'(i % OUT_PIX == 24)) begin
                errors++; $display("FAIL nom_accept[%0d] got %0d want %0d", i, accQ[i], (i / OUT_PIX) * 64 + (i % OUT_PIX) * 2 + int'(i % OUT_PIX == 24)); end
        end
        checks++; if (readGapViol != 0) begin errors++; $display("FAIL nom_throughput got %0d want 0", readGapViol); end
        checks++; if (holdViol != 0) begin errors++; $display("FAIL nom_hold got %0d want 0", holdViol); end
        checks++; if (doneCnt != 1) begin errors++; $display("FAIL nom_done_cnt got %0d want 1", doneCnt); end
        checks++; if (busyInDone !== 1'b1) begin errors++; $display("FAIL nom_busy_in_done got %0b want 1", busyInDone); end
        checks++; if (postSnap !== 32'd0) begin errors++; $display("FAIL nom_post_outs got %0h want 0", postSnap); end
        checks++; if (postBusy2 !== 1'b0) begin errors++; $display("FAIL nom_post_busy got %0b want 0", postBusy2); end
    endtask

    task automatic test_backpressure();
        int r;
        clear_knobs(); bpEn = 1;
        respond(3000, r);
        checks++; if (r != 1) begin errors++; $display("FAIL bp_result got %0d want 1", r); end
        checks++; if (bpXferCycles != 6) begin errors++; $display("FAIL bp_xfer_cycles got %0d want 6", bpXferCycles); end
        checks++; if (holdViol != 0) begin errors++; $display("FAIL bp_hold got %0d want 0", holdViol); end
        checks++; if (readGapViol != 1) begin errors++; $display("FAIL bp_gaps got %0d want 1", readGapViol); end
        checks++; if (readQ.size() != NUM_CH * OUT_PIX) begin errors++; $display("FAIL bp_reads got %0d want 150", readQ.size()); end
        if (readQ.size() > 63) begin
            checks++; if (readQ[62] != 76 || readQ[63] != 77) begin errors++; $display("FAIL bp_read_order got %0d,%0d want 76,77", readQ[62], readQ[63]); end
        end
        checks++; if (accQ.size() != NUM_CH * OUT_PIX) begin errors++; $display("FAIL bp_accepts got %0d want 150", accQ.size()); end
    endtask

    task automatic test_handshake();
        int r;
        clear_knobs(); convHold = 3; ackLevel = 1;
        respond(3000, r);
        checks++; if (r != 1) begin errors++; $display("FAIL hs_result got %0d want 1", r); end
        checks++; if (loadChQ.size() != NUM_CH) begin errors++; $display("FAIL hs_loads got %0d want %0d", loadChQ.size(), NUM_CH); end
        checks++; if (convEntries != NUM_CH) begin errors++; $display("FAIL hs_convs got %0d want %0d", convEntries, NUM_CH); end
        checks++; if (rdFromConv != NUM_CH) begin errors++; $display("FAIL hs_conv2rd got %0d want %0d", rdFromConv, NUM_CH); end
        checks++; if (convLowOk != NUM_CH) begin errors++; $display("FAIL hs_convvalid_drop got %0d want %0d", convLowOk, NUM_CH); end
        checks++; if (readQ.size() != NUM_CH * OUT_PIX) begin errors++; $display("FAIL hs_reads got %0d want 150", readQ.size()); end
        checks++; if (doneCnt != 1) begin errors++; $display("FAIL hs_done_cnt got %0d want 1", doneCnt); end
    endtask

    task automatic test_abort();
        int r;
        clear_knobs(); abortEn = 1;
        respond(3000, r);
        checks++; if (r != 2) begin errors++; $display("FAIL ab_result got %0d want 2", r); end
        checks++; if (accQ.size() != 82) begin errors++; $display("FAIL ab_accepts got %0d want 82", accQ.size()); end
        checks++; if (doneCnt != 0) begin errors++; $display("FAIL ab_done got %0d want 0", doneCnt); end
        checks++; if (postSnap !== 32'd0) begin errors++; $display("FAIL ab_post_outs got %0h want 0", postSnap); end
        checks++; if (postBusy2 !== 1'b0) begin errors++; $display("FAIL ab_post_busy got %0b want 0", postBusy2); end
        clear_knobs();
        respond(3000, r);
        checks++; if (r != 1) begin errors++; $display("FAIL ab_restart_result got %0d want 1", r); end
        checks++; if (loadChQ.size() != NUM_CH || loadChQ[0] != 0) begin errors++; $display("FAIL ab_restart_ch got size %0d want %0d from ch 0", loadChQ.size(), NUM_CH); end
        checks++; if (doneCnt != 1) begin errors++; $display("FAIL ab_restart_done got %0d want 1", doneCnt); end
    endtask

    task automatic test_start_busy();
        int r;
        clear_knobs(); startConv1 = 1; startDone = 1;
        respond(3000, r);
        checks++; if (r != 1) begin errors++; $display("FAIL sb_result got %0d want 1", r); end
        checks++; if (loadChQ.size() != NUM_CH) begin errors++; $display("FAIL sb_loads got %0d want %0d", loadChQ.size(), NUM_CH); end
        for (int i = 0; i < loadChQ.size() && i < NUM_CH; i++) begin
            checks++; if (loadChQ[i] != i) begin errors++; $display("FAIL sb_wgtch[%0d] got %0d want %0d", i, loadChQ[i], i); end
        end
        checks++; if (accQ.size() != NUM_CH * OUT_PIX) begin errors++; $display("FAIL sb_accepts got %0d want 150", accQ.size()); end
        checks++; if (doneCnt != 1) begin errors++; $display("FAIL sb_done got %0d want 1", doneCnt); end
        checks++; if (postSnap !== 32'd0) begin errors++; $display("FAIL sb_post_outs got %0h want 0", postSnap); end
        checks++; if (postBusy2 !== 1'b0) begin errors++; $display("FAIL sb_post_busy got %0b want 0", postBusy2); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); Start_i = 1'b1;
        @(negedge clk); Start_i = 1'b0; WgtLoadAck_i = 1'b1;
        @(negedge clk); WgtLoadAck_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ConvValid_o !== 1'b1) begin errors++; $display("FAIL ar_in_conv got %0b want 1", ConvValid_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (outs() !== 32'd0) begin errors++; $display("FAIL ar_async_outs got %0h want 0", outs()); end
        @(negedge clk); rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL ar_idle_busy got %0b want 0", Busy_o); end
        end
        Start_i = 1'b1;
        @(negedge clk); Start_i = 1'b0;
        checks++; if (WgtLoadReq_o !== 1'b1 || WgtCh_o !== 3'd0) begin errors++; $display("FAIL ar_restart got req %0b ch %0d want req 1 ch 0", WgtLoadReq_o, WgtCh_o); end
        Abort_i = 1'b1;
        @(negedge clk); Abort_i = 1'b0;
        checks++; if (outs() !== 32'd0) begin errors++; $display("FAIL ar_cleanup got %0h want 0", outs()); end
    endtask

    initial begin
        rst = 1'b1; Start_i = 0; Abort_i = 0; WgtLoadAck_i = 0; ConvReady_i = 0; DrainReady_i = 0;
        clear_knobs();
        test_reset();
        test_nominal();
        test_backpressure();
        test_handshake();
        test_abort();
        test_start_busy();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
